// File: rtl/mult_arbiter.sv
// Purpose: round-robin share of one external combinational multiplier between two requesters.
// Latency: grant in cycle t, product sampled at end of t+LAT, RSP_VLD asserted from t+LAT+1.
// Backpressure: response held until RSP_RDY of the granted requester; no new grant until then.
module mult_arbiter #(
    parameter int N   = 32,
    parameter int LAT = 2
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic [1:0]     REQ_VLD,
    output logic [1:0]     REQ_RDY,
    input  logic [N-1:0]   REQ_A0,
    input  logic [N-1:0]   REQ_B0,
    input  logic [N-1:0]   REQ_A1,
    input  logic [N-1:0]   REQ_B1,
    output logic [1:0]     RSP_VLD,
    input  logic [1:0]     RSP_RDY,
    output logic [2*N-1:0] RSP_Z,
    output logic [N-1:0]   MULT_A,
    output logic [N-1:0]   MULT_B,
    input  logic [2*N-1:0] MULT_Z,
    output logic           BUSY
);

    // Counter only has to hold LAT-1.
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      rst_sync;
    logic            rst_int_n;
    logic [CW-1:0]   cnt;
    logic            gid;       // requester owning the operation in flight
    logic            last;      // requester granted most recently
    logic [1:0]      grant;

    // Reset asserts immediately, releases two clock edges after RST_n rises.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // State register.
    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        grant     = 2'b00;
        RSP_VLD   = 2'b00;
        unique case (state)
            ST_IDLE: begin
                // Grant is gated while the internal reset is still held.
                if (rst_int_n) begin
                    case (REQ_VLD)
                        2'b01:   grant = 2'b01;
                        2'b10:   grant = 2'b10;
                        2'b11:   grant = last ? 2'b01 : 2'b10;
                        default: grant = 2'b00;
                    endcase
                end
                if (grant != 2'b00) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                RSP_VLD = gid ? 2'b10 : 2'b01;
                // Only the owning requester's ready counts.
                if (RSP_RDY[gid]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign REQ_RDY = grant;
    assign BUSY    = (state != ST_IDLE);

    // Operand capture on grant, latency count, product capture when the count expires.
    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            MULT_A <= '0;
            MULT_B <= '0;
            RSP_Z  <= '0;
            cnt    <= '0;
            gid    <= 1'b0;
            last   <= 1'b1;
        end else begin
            if (state == ST_IDLE && grant != 2'b00) begin
                MULT_A <= grant[1] ? REQ_A1 : REQ_A0;
                MULT_B <= grant[1] ? REQ_B1 : REQ_B0;
                gid    <= grant[1];
                last   <= grant[1];
                cnt    <= CW'(LAT - 1);
            end else if (state == ST_BUSY) begin
                if (cnt == '0) begin
                    RSP_Z <= MULT_Z;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Purpose: checks mult_arbiter at LAT=2, 1 and 4 against a rule-level model (arbitration, product, latency).
// Latency: each instance runs its own sequence on a shared clock; all finish in a few hundred cycles.
// Backpressure: response ready is withheld for random and fixed spans to check that responses are held.
module tb_mult_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit fin [3];

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
    } vec_t;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endfunction

    // Reference product: plain signed arithmetic on the operands.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Reference arbitration: a lone requester wins; on a tie the one not served last wins.
    function automatic logic [1:0] ref_grant(input logic [1:0] vld, input int last);
        if (vld == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return vld;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        logic        rst_n = 1'b0;
        logic [1:0]  req_vld = 2'b00;
        logic [1:0]  req_rdy;
        logic [31:0] a0, b0, a1, b1;
        logic [1:0]  rsp_vld;
        logic [1:0]  rsp_rdy = 2'b00;
        logic [63:0] rsp_z;
        logic [31:0] mult_a, mult_b;
        logic [63:0] mult_z;
        logic        busy;
        int          model_last = 1;

        mult_arbiter #(.N(32), .LAT(L)) dut (
            .CLK(clk), .RST_n(rst_n),
            .REQ_VLD(req_vld), .REQ_RDY(req_rdy),
            .REQ_A0(a0), .REQ_B0(b0), .REQ_A1(a1), .REQ_B1(b1),
            .RSP_VLD(rsp_vld), .RSP_RDY(rsp_rdy), .RSP_Z(rsp_z),
            .MULT_A(mult_a), .MULT_B(mult_b), .MULT_Z(mult_z),
            .BUSY(busy)
        );

        // Stand-in for the combinational multiplier.
        assign mult_z = $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});

        function automatic string tag(input string nm);
            return $sformatf("L%0d %s", L, nm);
        endfunction

        task automatic do_reset();
            rst_n   = 1'b0;
            req_vld = 2'b11;
            rsp_rdy = 2'b00;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check(tag("rdy_in_reset"), 64'(req_rdy), 64'd0);
            req_vld = 2'b00;
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            model_last = 1;
        endtask

        // Entered and left just after a rising edge; the grant cycle is the first cycle.
        task automatic issue(input logic [1:0] vld, input logic [31:0] xa0, input logic [31:0] xb0,
                             input logic [31:0] xa1, input logic [31:0] xb1,
                             input logic [1:0] exp_gnt, input string nm);
            req_vld = vld; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
            @(negedge clk);
            check(tag({nm, " grant"}), 64'(req_rdy), 64'(exp_gnt));
            check(tag({nm, " idle"}), 64'(busy), 64'd0);
            @(posedge clk); #1;
            if (exp_gnt != 2'b00) begin
                model_last = exp_gnt[1] ? 1 : 0;
                check(tag({nm, " mult_a"}), 64'(mult_a), 64'(exp_gnt[1] ? xa1 : xa0));
                check(tag({nm, " mult_b"}), 64'(mult_b), 64'(exp_gnt[1] ? xb1 : xb0));
            end
        endtask

        // Waits for the response, checks latency and value, holds it for 'hold' cycles, then takes it.
        task automatic wait_rsp(input int id, input logic [63:0] exp_z, input int hold, input string nm);
            int k;
            bit rdy_bad;
            logic [1:0] exp_v;
            exp_v   = (id == 1) ? 2'b10 : 2'b01;
            rdy_bad = 1'b0;
            k       = 1;
            @(negedge clk);
            while (rsp_vld == 2'b00 && k < 60) begin
                if (req_rdy != 2'b00 || busy != 1'b1) rdy_bad = 1'b1;
                @(posedge clk); #1;
                @(negedge clk);
                k++;
            end
            if (req_rdy != 2'b00) rdy_bad = 1'b1;
            check(tag({nm, " latency"}), 64'(k), 64'(L + 1));
            check(tag({nm, " rsp_vld"}), 64'(rsp_vld), 64'(exp_v));
            check(tag({nm, " rsp_z"}), rsp_z, exp_z);
            check(tag({nm, " no_grant_while_busy"}), 64'(rdy_bad), 64'd0);
            repeat (hold) begin
                @(posedge clk); #1;
                rsp_rdy = ~exp_v;
                @(negedge clk);
                check(tag({nm, " held_vld"}), 64'(rsp_vld), 64'(exp_v));
                check(tag({nm, " held_z"}), rsp_z, exp_z);
                check(tag({nm, " held_rdy"}), 64'(req_rdy), 64'd0);
                check(tag({nm, " held_busy"}), 64'(busy), 64'd1);
            end
            @(posedge clk); #1;
            rsp_rdy = exp_v;
            @(posedge clk); #1;
            rsp_rdy = 2'b00;
        endtask

        initial begin
            vec_t        tbl [7];
            logic [1:0]  v;
            logic [1:0]  gnt;
            logic [31:0] ra0, rb0, ra1, rb1;
            bit          late_vld;
            int          rid;

            tbl[0] = '{1'b0, 32'd3,         32'd5,         64'd15};
            tbl[1] = '{1'b1, 32'hFFFFFFFE,  32'd3,         64'hFFFFFFFF_FFFFFFFA};
            tbl[2] = '{1'b0, 32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF_00000001};
            tbl[3] = '{1'b1, 32'h80000000,  32'h80000000,  64'h40000000_00000000};
            tbl[4] = '{1'b0, 32'h80000000,  32'd1,         64'hFFFFFFFF_80000000};
            tbl[5] = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'd1};
            tbl[6] = '{1'b0, 32'd0,         32'h12345678,  64'd0};

            // Reset state
            do_reset();
            @(negedge clk);
            check(tag("rst req_rdy"), 64'(req_rdy), 64'd0);
            check(tag("rst rsp_vld"), 64'(rsp_vld), 64'd0);
            check(tag("rst rsp_z"), rsp_z, 64'd0);
            check(tag("rst mult_a"), 64'(mult_a), 64'd0);
            check(tag("rst mult_b"), 64'(mult_b), 64'd0);
            check(tag("rst busy"), 64'(busy), 64'd0);
            @(posedge clk); #1;

            // Fixed vectors, the other requester's operands are decoys
            for (int i = 0; i < 7; i++) begin
                v = tbl[i].id ? 2'b10 : 2'b01;
                issue(v, tbl[i].id ? ~tbl[i].a : tbl[i].a, tbl[i].id ? ~tbl[i].b : tbl[i].b,
                      tbl[i].id ? tbl[i].a : ~tbl[i].a, tbl[i].id ? tbl[i].b : ~tbl[i].b, v, "tbl");
                req_vld = 2'b00;
                wait_rsp(tbl[i].id, tbl[i].z, 0, "tbl");
            end

            // Backpressure with requester 1 waiting throughout
            issue(2'b01, 32'd3, 32'd5, 32'd9, 32'd9, 2'b01, "bp0");
            req_vld = 2'b10;
            wait_rsp(0, 64'd15, 10, "bp0");
            issue(2'b10, 32'd3, 32'd5, 32'd9, 32'd9, 2'b10, "bp1");
            req_vld = 2'b00;
            wait_rsp(1, 64'd81, 0, "bp1");

            // Ties straight after reset alternate starting with requester 0
            do_reset();
            issue(2'b11, 32'd7, 32'd6, 32'd9, 32'd9, 2'b01, "tie1");
            wait_rsp(0, 64'd42, 0, "tie1");
            issue(2'b11, 32'd7, 32'd6, 32'd9, 32'd9, 2'b10, "tie2");
            wait_rsp(1, 64'd81, 0, "tie2");
            issue(2'b11, 32'd7, 32'd6, 32'd9, 32'd9, 2'b01, "tie3");
            req_vld = 2'b00;
            wait_rsp(0, 64'd42, 0, "tie3");

            // Reset while an operation is in flight
            issue(2'b01, 32'd11, 32'd13, 32'd2, 32'd2, 2'b01, "mid");
            req_vld = 2'b11;
            #2;
            rst_n = 1'b0;
            #1;
            check(tag("mid req_rdy"), 64'(req_rdy), 64'd0);
            check(tag("mid rsp_vld"), 64'(rsp_vld), 64'd0);
            check(tag("mid rsp_z"), rsp_z, 64'd0);
            check(tag("mid mult_a"), 64'(mult_a), 64'd0);
            check(tag("mid mult_b"), 64'(mult_b), 64'd0);
            check(tag("mid busy"), 64'(busy), 64'd0);
            req_vld = 2'b00;
            repeat (2) begin @(posedge clk); #1; end
            rst_n = 1'b1;
            late_vld = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (rsp_vld != 2'b00) late_vld = 1'b1;
                @(posedge clk); #1;
            end
            check(tag("mid no_rsp_after_reset"), 64'(late_vld), 64'd0);
            model_last = 1;
            issue(2'b11, 32'd2, 32'd21, 32'd4, 32'd4, 2'b01, "post");
            req_vld = 2'b00;
            wait_rsp(0, 64'd42, 0, "post");

            // Random traffic against the model
            for (int i = 0; i < 30; i++) begin
                v   = 2'($urandom_range(1, 3));
                ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
                if ($urandom_range(0, 3) == 0) ra0 = 32'h80000000;
                if ($urandom_range(0, 3) == 0) rb1 = 32'h7FFFFFFF;
                gnt = ref_grant(v, model_last);
                rid = gnt[1] ? 1 : 0;
                issue(v, ra0, rb0, ra1, rb1, gnt, "rnd");
                req_vld = 2'b00;
                wait_rsp(rid, ref_prod(rid == 1 ? ra1 : ra0, rid == 1 ? rb1 : rb0),
                         int'($urandom_range(0, 3)), "rnd");
            end

            fin[g] = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(fin[0] && fin[1] && fin[2]) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            nvec++;
            nerr++;
            $display("FAIL timeout: ran %0d cycles, sequences still open", cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
